// File: rtl/in_fifo_multi_sync_if.sv
// Bus bundle for in_fifo_multi_sync: shared write/read strobes, per-channel
// write data, registered read data and the occupancy/status flags.
//
// Handshake: the producer raises WREN with D; the write is taken at the CLK
// edge when FULL is low, or when a read is taken at that same edge. The
// consumer raises RDEN; the read is taken at the CLK edge when EMPTY is low,
// and Q carries the popped entry from the following cycle onward. A strobe
// that is not taken is dropped and recorded in OVERFLOW / UNDERFLOW.
interface in_fifo_multi_sync_if #(
    parameter int NUM_CH = 10,
    parameter int DIN_W  = 4,
    parameter int DEPTH  = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                      WREN;
    logic [NUM_CH*DIN_W-1:0]   D;
    logic                      RDEN;
    logic [NUM_CH*2*DIN_W-1:0] Q;
    logic                      EMPTY;
    logic                      ALMOSTEMPTY;
    logic                      FULL;
    logic                      ALMOSTFULL;
    logic [CW-1:0]             COUNT;
    logic                      OVERFLOW;
    logic                      UNDERFLOW;

    modport master (
        output WREN, D, RDEN,
        input  Q, EMPTY, ALMOSTEMPTY, FULL, ALMOSTFULL, COUNT, OVERFLOW, UNDERFLOW
    );

    modport slave (
        input  WREN, D, RDEN,
        output Q, EMPTY, ALMOSTEMPTY, FULL, ALMOSTFULL, COUNT, OVERFLOW, UNDERFLOW
    );
endinterface

// File: rtl/in_fifo_multi_sync.sv
// Single-clock multi-channel input FIFO. NUM_CH channels share one write and
// one read strobe. In ARRAY_MODE_4_X_8 two consecutive writes are packed into
// one entry (first write = low half); in ARRAY_MODE_4_X_4 each write is one
// entry with a zero high half. Flags are registered from the next COUNT.
module in_fifo_multi_sync #(
    parameter int NUM_CH             = 10,
    parameter int DIN_W              = 4,
    parameter int DEPTH              = 8,
    parameter     ARRAY_MODE         = "ARRAY_MODE_4_X_8",
    parameter int ALMOST_EMPTY_VALUE = 1,
    parameter int ALMOST_FULL_VALUE  = 1
) (
    input logic                 CLK,
    input logic                 RESET,
    in_fifo_multi_sync_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = NUM_CH * DIN_W;
    localparam int QW = 2 * DW;
    localparam bit PACK    = (ARRAY_MODE == "ARRAY_MODE_4_X_8");
    localparam bit MODE_OK = PACK || (ARRAY_MODE == "ARRAY_MODE_4_X_4");

    // Reject parameter sets the datapath is not built for.
    generate
        if (NUM_CH < 1 || NUM_CH > 16 || DIN_W < 1 || DIN_W > 16 ||
            DEPTH < 4 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0 || !MODE_OK ||
            ALMOST_EMPTY_VALUE < 1 || ALMOST_EMPTY_VALUE > DEPTH / 2 ||
            ALMOST_FULL_VALUE < 1 || ALMOST_FULL_VALUE > DEPTH / 2) begin : g_bad_param
            $fatal(1, "attribute syntax error: illegal parameter value for in_fifo_multi_sync");
        end
    endgenerate

    logic [QW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic [QW-1:0] q_r;
    logic [QW-1:0] wr_word;
    logic          empty_r;
    logic          aempty_r;
    logic          full_r;
    logic          afull_r;
    logic          ovf_r;
    logic          unf_r;
    logic          rd_acc;
    logic          wr_acc;
    logic          commit;
    logic          phase;   // 1 = the next accepted write completes an entry

    // Acceptance from the registered flags, and the next occupancy.
    always_comb begin
        rd_acc    = bus.RDEN & ~empty_r;
        wr_acc    = bus.WREN & (~full_r | rd_acc);
        commit    = wr_acc & phase;
        count_nxt = count;
        if (commit && !rd_acc) begin
            count_nxt = count + CW'(1);
        end else if (rd_acc && !commit) begin
            count_nxt = count - CW'(1);
        end
    end

    generate
        if (PACK) begin : g_pack
            logic [DW-1:0] hold;

            // Pack phase and per-channel low-half capture; reset drops a half entry.
            always_ff @(posedge CLK) begin
                if (RESET) begin
                    phase <= 1'b0;
                    hold  <= '0;
                end else if (wr_acc) begin
                    phase <= ~phase;
                    if (!phase) begin
                        hold <= bus.D;
                    end
                end
            end

            for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
                assign wr_word[k*2*DIN_W +: 2*DIN_W] = {bus.D[k*DIN_W +: DIN_W], hold[k*DIN_W +: DIN_W]};
            end
        end else begin : g_single
            // Every accepted write completes an entry.
            assign phase = 1'b1;

            for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
                assign wr_word[k*2*DIN_W +: 2*DIN_W] = {{DIN_W{1'b0}}, bus.D[k*DIN_W +: DIN_W]};
            end
        end
    endgenerate

    // Storage array; contents are meaningless until written.
    always_ff @(posedge CLK) begin
        if (commit && !RESET) begin
            mem[wr_ptr] <= wr_word;
        end
    end

    // Pointers, occupancy, read register and status flags.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            q_r      <= '0;
            empty_r  <= 1'b1;
            aempty_r <= 1'b1;
            full_r   <= 1'b0;
            afull_r  <= 1'b0;
            ovf_r    <= 1'b0;
            unf_r    <= 1'b0;
        end else begin
            if (commit) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + AW'(1);
                q_r    <= mem[rd_ptr];
            end
            count    <= count_nxt;
            empty_r  <= (count_nxt == '0);
            aempty_r <= (count_nxt <= CW'(ALMOST_EMPTY_VALUE));
            full_r   <= (count_nxt == CW'(DEPTH));
            afull_r  <= (count_nxt >= CW'(DEPTH - ALMOST_FULL_VALUE));
            if (bus.WREN && !wr_acc) begin
                ovf_r <= 1'b1;
            end
            if (bus.RDEN && empty_r) begin
                unf_r <= 1'b1;
            end
        end
    end

    assign bus.Q           = q_r;
    assign bus.EMPTY       = empty_r;
    assign bus.ALMOSTEMPTY = aempty_r;
    assign bus.FULL        = full_r;
    assign bus.ALMOSTFULL  = afull_r;
    assign bus.COUNT       = count;
    assign bus.OVERFLOW    = ovf_r;
    assign bus.UNDERFLOW   = unf_r;
endmodule
